psum_acc: RTL and testbench

PSUM_ACC -- requirements
Module: psum_acc

---
 rtl/psum_acc_pkg.sv | 20 ++
 rtl/psum_acc.sv | 131 +++++++++++++
 tb/tb_psum_acc.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_pkg.sv
// Shared configuration for the processing-element control path: datapath
// widths and the state encoding of the partial-sum accumulator.
package PECtlCfg;

  // Width of the signed partial sum produced by the arithmetic unit.
  localparam int AuODWd = 16;

  // Default width of the per-output term-count field.
  localparam int AccNumWdDef = 8;

  // Accumulator width: enough headroom for 2^AccNumWdDef full-scale terms.
  localparam int AccODWd = AuODWd + AccNumWdDef;

  // ACC collects terms; HOLD presents a finished result until it is taken.
  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

endpackage

// File: rtl/psum_acc.sv
// Partial-sum accumulator: sums a programmable number of signed terms from
// the arithmetic unit and hands the total downstream.
//
// Handshakes: upstream, a term transfers on a cycle where sum_rdy and sum_ack
// are both high; sum_ack does not depend on sum_rdy. Downstream, o_acc and
// acc_zero are valid while acc_rdy is high and are held stable until a cycle
// with acc_ack and i_cont_stall both high. i_cont_clear overrides everything.
import PECtlCfg::*;

module psum_acc #(
  parameter int AccNumWd = 8
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_cont_stall,
  input  logic                i_cont_clear,
  input  logic [AccNumWd-1:0] i_cont_accNum,
  input  logic [AuODWd-1:0]   i_sum,
  input  logic                sum_rdy,
  output logic                sum_ack,
  input  logic                sum_zero,
  output logic [AccODWd-1:0]  o_acc,
  output logic                acc_rdy,
  input  logic                acc_ack,
  output logic                acc_zero,
  output acc_state_e          o_dbg_state
);

  acc_state_e          state_q, state_d;
  logic [AccODWd-1:0]  acc_q, acc_d;
  logic [AccNumWd-1:0] cnt_q, cnt_d;
  logic [AccNumWd-1:0] accnum_q, accnum_d;
  logic                zflag_q, zflag_d;
  logic [AccODWd-1:0]  oacc_q, oacc_d;
  logic                acc_rdy_q, acc_rdy_d;
  logic                acc_zero_q, acc_zero_d;

  logic                accept;
  logic [AccNumWd-1:0] num_eff;
  logic [AccNumWd-1:0] last_cnt;
  logic                last_term;
  logic [AccODWd-1:0]  term;
  logic [AccODWd-1:0]  sum_nxt;

  // Term acceptance, target count and the running sum including this term.
  always_comb begin
    sum_ack   = i_rstn && i_cont_stall && (state_q == ACC) && !i_cont_clear;
    accept    = sum_rdy && sum_ack;
    // The term count is taken live on the first term of an output and from
    // the latched copy afterwards, so mid-sum changes wait for the next output.
    num_eff   = (cnt_q == '0) ? i_cont_accNum : accnum_q;
    // A count of 0 wraps to all-ones here, which selects 2^AccNumWd terms.
    last_cnt  = num_eff - AccNumWd'(1);
    last_term = (cnt_q == last_cnt);
    // Bubbles (sum_zero low) still count as terms but contribute nothing.
    term      = sum_zero ? AccODWd'($signed(i_sum)) : '0;
    sum_nxt   = acc_q + term;
  end

  // Next-state logic: clear first, then freeze on stall, then handshakes.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    accnum_d   = accnum_q;
    zflag_d    = zflag_q;
    oacc_d     = oacc_q;
    acc_rdy_d  = acc_rdy_q;
    acc_zero_d = acc_zero_q;

    if (i_cont_clear) begin
      // Flush: drop the partial sum and any result still waiting in HOLD.
      state_d   = ACC;
      acc_d     = '0;
      cnt_d     = '0;
      zflag_d   = 1'b0;
      acc_rdy_d = 1'b0;
    end else if (i_cont_stall) begin
      if (accept) begin
        if (cnt_q == '0) begin
          accnum_d = i_cont_accNum;
        end
        if (last_term) begin
          oacc_d     = sum_nxt;
          acc_zero_d = zflag_q | sum_zero;
          acc_rdy_d  = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
          zflag_d    = 1'b0;
          state_d    = HOLD;
        end else begin
          acc_d   = sum_nxt;
          cnt_d   = cnt_q + AccNumWd'(1);
          zflag_d = zflag_q | sum_zero;
        end
      end else if ((state_q == HOLD) && acc_ack) begin
        acc_rdy_d = 1'b0;
        state_d   = ACC;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      accnum_q   <= '0;
      zflag_q    <= 1'b0;
      oacc_q     <= '0;
      acc_rdy_q  <= 1'b0;
      acc_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      accnum_q   <= accnum_d;
      zflag_q    <= zflag_d;
      oacc_q     <= oacc_d;
      acc_rdy_q  <= acc_rdy_d;
      acc_zero_q <= acc_zero_d;
    end
  end

  assign o_acc       = oacc_q;
  assign acc_rdy     = acc_rdy_q;
  assign acc_zero    = acc_zero_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_psum_acc.sv
// Bench for psum_acc: directed scenarios plus a randomized run, checked by a
// scoreboard fed from a sum-of-terms reference model.
import PECtlCfg::*;

module tb_psum_acc;

  localparam int AccNumWd = 8;
  localparam int W        = AccODWd + 1;   // {acc_zero, o_acc}

  logic                i_clk = 1'b0;
  logic                i_rstn;
  logic                i_cont_stall;
  logic                i_cont_clear;
  logic [AccNumWd-1:0] i_cont_accNum;
  logic [AuODWd-1:0]   i_sum;
  logic                sum_rdy;
  logic                sum_ack;
  logic                sum_zero;
  logic [AccODWd-1:0]  o_acc;
  logic                acc_rdy;
  logic                acc_ack;
  logic                acc_zero;
  acc_state_e          o_dbg_state;

  // Stall and acc_ack are either driven by the directed sequence or randomized.
  logic stall_auto = 1'b0, stall_man = 1'b1, stall_rand = 1'b1;
  logic ack_auto   = 1'b0, ack_man   = 1'b0, ack_rand   = 1'b1;
  assign i_cont_stall = stall_auto ? stall_rand : stall_man;
  assign acc_ack      = ack_auto ? ack_rand : ack_man;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state: a plain running total of accepted terms.
  longint m_sum = 0;
  logic   m_z   = 1'b0;
  int     m_cnt = 0;
  int     m_target = 1;

  psum_acc #(.AccNumWd(AccNumWd)) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_cont_stall  (i_cont_stall),
    .i_cont_clear  (i_cont_clear),
    .i_cont_accNum (i_cont_accNum),
    .i_sum         (i_sum),
    .sum_rdy       (sum_rdy),
    .sum_ack       (sum_ack),
    .sum_zero      (sum_zero),
    .o_acc         (o_acc),
    .acc_rdy       (acc_rdy),
    .acc_ack       (acc_ack),
    .acc_zero      (acc_zero),
    .o_dbg_state   (o_dbg_state)
  );

  // Clock and random control sources.
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    #1;
    stall_rand = ($urandom_range(0, 9) < 8);
    ack_rand   = ($urandom_range(0, 9) < 6);
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: an output is the sum of the next N accepted terms, N read at the first.
  task automatic model_accept(input logic signed [AuODWd-1:0] v, input logic z);
    longint t;
    if (m_cnt == 0) m_target = (i_cont_accNum == 0) ? (1 << AccNumWd) : int'(i_cont_accNum);
    t = z ? longint'(v) : 64'sd0;
    m_sum = m_sum + t;
    m_z   = m_z | z;
    m_cnt++;
    if (m_cnt == m_target) begin
      exp_q.push_back({m_z, m_sum[AccODWd-1:0]});
      m_sum = 0;
      m_z   = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic model_flush();
    m_sum = 0;
    m_z   = 1'b0;
    m_cnt = 0;
  endtask

  // Driver: present one term from just after a rising edge until it is taken.
  task automatic send_term(input logic signed [AuODWd-1:0] v, input logic z);
    int guard = 0;
    i_sum    = v;
    sum_zero = z;
    sum_rdy  = 1'b1;
    forever begin
      @(negedge i_clk);
      if (sum_ack) break;
      guard++;
      if (guard > 300) begin
        check("send_timeout", 1, 0);
        sum_rdy = 1'b0;
        return;
      end
    end
    model_accept(v, z);
    @(posedge i_clk);
    #1;
    sum_rdy = 1'b0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare each new result with the scoreboard and hold it stable.
  logic         rdy_prev = 1'b0;
  logic [W-1:0] cur_exp  = '0;
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      rdy_prev = 1'b0;
    end else begin
      if (acc_rdy && !rdy_prev) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
          cur_exp = {acc_zero, o_acc};
        end else begin
          cur_exp = exp_q.pop_front();
          check("o_acc", o_acc, cur_exp[AccODWd-1:0]);
          check("acc_zero", acc_zero, cur_exp[AccODWd]);
        end
      end else if (acc_rdy && rdy_prev) begin
        check("hold_stable", {acc_zero, o_acc}, cur_exp);
      end
      rdy_prev = acc_rdy;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    check("watchdog", 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Directed scenarios then randomized traffic.
  initial begin
    int outs0;
    i_rstn = 1'b0; i_cont_clear = 1'b0; i_cont_accNum = 8'd4;
    i_sum = '0; sum_rdy = 1'b0; sum_zero = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_sum_ack", sum_ack, 0);
    check("rst_o_acc", o_acc, 0);
    check("rst_acc_rdy", acc_rdy, 0);
    check("rst_acc_zero", acc_zero, 0);
    check("rst_state", o_dbg_state, ACC);
    step();
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("post_rst_sum_ack", sum_ack, 1);
    step();

    // Four signed terms, result held while acc_ack stays low.
    ack_man = 1'b0;
    i_cont_accNum = 8'd4;
    send_term(16'sd3, 1'b1);
    send_term(-16'sd5, 1'b1);
    send_term(16'sd7, 1'b1);
    send_term(16'sd1, 1'b1);
    @(negedge i_clk);
    check("rdy_after_last", acc_rdy, 1);
    check("sum4_o_acc", o_acc, 6);
    sum_rdy = 1'b1; i_sum = 16'sd9; sum_zero = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      check("hold_sum_ack", sum_ack, 0);
      check("hold_o_acc", o_acc, 6);
    end
    sum_rdy = 1'b0;
    ack_man = 1'b1;
    step();
    @(negedge i_clk);
    check("ack_drop_rdy", acc_rdy, 0);
    check("ack_resume_sum_ack", sum_ack, 1);
    step();

    // Bubble terms add zero but still count.
    i_cont_accNum = 8'd2;
    send_term(16'sd100, 1'b0);
    send_term(16'sd20, 1'b1);
    send_term(16'sd100, 1'b0);
    send_term(16'sd20, 1'b0);
    drain(20);

    // Count 0 means 256 full-scale terms, exactly one output, no wrap.
    outs0 = n_out;
    i_cont_accNum = 8'd0;
    for (int i = 0; i < 256; i++) send_term(16'sd32767, 1'b1);
    @(negedge i_clk);
    check("full256_o_acc", o_acc, 256 * 32767);
    drain(20);
    repeat (3) step();
    check("full256_one_output", n_out - outs0, 1);

    // Stall freezes acceptance mid-sum.
    i_cont_accNum = 8'd4;
    send_term(16'sd10, 1'b1);
    send_term(-16'sd3, 1'b1);
    stall_man = 1'b0;
    sum_rdy = 1'b1; i_sum = 16'sd77; sum_zero = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      check("stall_sum_ack", sum_ack, 0);
    end
    sum_rdy = 1'b0;
    step();
    stall_man = 1'b1;
    send_term(16'sd50, 1'b1);
    send_term(16'sd1, 1'b1);
    drain(20);

    // Clear in HOLD discards the pending result, even while stalled.
    ack_man = 1'b0;
    send_term(16'sd1, 1'b1);
    send_term(16'sd2, 1'b1);
    send_term(16'sd3, 1'b1);
    send_term(16'sd4, 1'b1);
    step();
    i_cont_clear = 1'b1; stall_man = 1'b0;
    @(negedge i_clk);
    check("clear_sum_ack", sum_ack, 0);
    step();
    i_cont_clear = 1'b0; stall_man = 1'b1;
    @(negedge i_clk);
    check("clear_drop_rdy", acc_rdy, 0);
    check("clear_state", o_dbg_state, ACC);
    step();
    ack_man = 1'b1;
    send_term(16'sd5, 1'b1);
    send_term(16'sd6, 1'b1);
    send_term(16'sd7, 1'b1);
    send_term(16'sd8, 1'b1);
    drain(20);

    // Clear mid-sum drops the partial total.
    send_term(16'sd111, 1'b1);
    send_term(16'sd222, 1'b1);
    i_cont_clear = 1'b1;
    step();
    i_cont_clear = 1'b0;
    model_flush();
    send_term(-16'sd4, 1'b1);
    send_term(16'sd9, 1'b0);
    send_term(-16'sd8, 1'b1);
    send_term(16'sd2, 1'b1);
    drain(20);

    // Asynchronous reset mid-sum zeroes outputs immediately.
    send_term(16'sd40, 1'b1);
    send_term(16'sd41, 1'b1);
    #2;
    i_rstn = 1'b0;
    #1;
    check("arst_o_acc", o_acc, 0);
    check("arst_acc_rdy", acc_rdy, 0);
    check("arst_acc_zero", acc_zero, 0);
    check("arst_sum_ack", sum_ack, 0);
    model_flush();
    step();
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("arst_resume", sum_ack, 1);
    step();

    // Randomized traffic with random stall, ack, gaps and count changes.
    stall_auto = 1'b1;
    ack_auto   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) i_cont_accNum = 8'($urandom_range(1, 5));
      send_term(16'($urandom_range(0, 65535)), ($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 2)) step();
    end
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
